// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    // Frame receiver states: wait for start bit, shift data, take parity, take stop.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Prefix bytes folded into flags instead of being reported as codes.
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // err_type encodings; 00 is only ever seen out of reset.
    localparam logic [1:0] PS2_ERR_NONE    = 2'b00;
    localparam logic [1:0] PS2_ERR_PARITY  = 2'b01;
    localparam logic [1:0] PS2_ERR_STOP    = 2'b10;
    localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b11;

    // Odd parity holds when the data bits and the parity bit XOR to 1.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser, level-persistence glitch filter and falling-edge
// pulse for the raw PS/2 clock.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall_q, fall_d;

    // Bring the asynchronous pin into the clock domain; idle level is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], raw_i};
    end

    // Filtered level follows the synchronised level only after it has held
    // a new value for FILTER_LEN consecutive cycles; any bounce back restarts.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        filt_d = filt_q;
        cnt_d  = '0;
        fall_d = 1'b0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
                fall_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Filter state register; fall_q is high in the cycle the filtered clock drops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update from the same pre-edge values.
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= fall_d;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard frame receiver: validates 11-bit frames, folds E0/F0
// prefixes into flags and emits one scan-code event or an error pulse.
// The break flag output is named release_flag because release is a
// reserved word in SystemVerilog.
module ps2_scan_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] scan_code,
    output logic       extended,
    output logic       release_flag,
    output logic       code_valid,
    output logic       frame_err,
    output logic [1:0] err_type
);
    import ps2_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic       edge_fall;
    logic [1:0] dat_sync_q;
    logic       dat;

    ps2_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [7:0] scan_q, scan_d;
    logic       ext_out_q, ext_out_d;
    logic       rel_out_q, rel_out_d;
    logic       code_valid_q, code_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0] err_type_q, err_type_d;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .raw_i  (PS2_CLK),
        .fall_o (edge_fall)
    );

    // Data is only sampled at filtered clock edges, so a plain synchroniser suffices.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) dat_sync_q <= 2'b11;
        else       dat_sync_q <= {dat_sync_q[0], PS2_DAT};
    end
    assign dat = dat_sync_q[1];

    // Frame FSM, prefix folding, timeout and output event generation.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        tmo_d        = tmo_q;
        scan_d       = scan_q;
        ext_out_d    = ext_out_q;
        rel_out_d    = rel_out_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        err_type_d   = err_type_q;

        // Inter-edge watchdog runs only inside a frame.
        if (state_q == IDLE || edge_fall) tmo_d = '0;
        else                              tmo_d = tmo_q + TW'(1);

        if (edge_fall) begin
            case (state_q)
                IDLE: begin
                    // A high start bit is treated as noise.
                    if (!dat) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = dat;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!ps2_parity_ok(shift_q, parity_q)) begin
                        frame_err_d = 1'b1;
                        err_type_d  = PS2_ERR_PARITY;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end else if (!dat) begin
                        frame_err_d = 1'b1;
                        err_type_d  = PS2_ERR_STOP;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end else if (shift_q == PS2_PREFIX_EXT) begin
                        ext_d = 1'b1;
                    end else if (shift_q == PS2_PREFIX_BRK) begin
                        brk_d = 1'b1;
                    end else begin
                        scan_d       = shift_q;
                        ext_out_d    = ext_q;
                        rel_out_d    = brk_q;
                        code_valid_d = 1'b1;
                        ext_d        = 1'b0;
                        brk_d        = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // An edge arriving on the terminal cycle takes the branch above instead.
            state_d     = IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
            err_type_d  = PS2_ERR_TIMEOUT;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            tmo_q        <= '0;
            scan_q       <= '0;
            ext_out_q    <= 1'b0;
            rel_out_q    <= 1'b0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_type_q   <= PS2_ERR_NONE;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            tmo_q        <= tmo_d;
            scan_q       <= scan_d;
            ext_out_q    <= ext_out_d;
            rel_out_q    <= rel_out_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            err_type_q   <= err_type_d;
        end
    end

    assign scan_code    = scan_q;
    assign extended     = ext_out_q;
    assign release_flag = rel_out_q;
    assign code_valid   = code_valid_q;
    assign frame_err    = frame_err_q;
    assign err_type     = err_type_q;

endmodule
